// File: rtl/uart_tx_message_sender_if.sv
// Message-sender bus: byte writes and send request in, serial line and status out.
// The master side loads and launches messages; the slave side is the sender itself.
interface uart_tx_message_sender_if;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_send;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_count;
  logic       o_full;

  modport master (
    output i_wr_en, i_wr_data, i_send,
    input  o_tx, o_busy, o_done, o_count, o_full
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_send,
    output o_tx, o_busy, o_done, o_count, o_full
  );
endinterface

// File: rtl/uart_tx_message_sender.sv
// Buffers up to MSG_LEN bytes, then sends them back-to-back as 8N1 UART frames
// (LSB first, idle high) and pulses o_done once the last stop bit has been sent.
module uart_tx_message_sender #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  uart_tx_message_sender_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        MSG_LEN_C = 3'(MSG_LEN);

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        byte_idx;
  logic [2:0]        count;
  logic              tx;
  logic              busy;
  logic              done;
  logic              full;
  logic              wr_fire;
  logic [7:0]        msg_mem [MSG_LEN];

  assign full    = (count == MSG_LEN_C);
  // A send request in the same cycle wins over a write.
  assign wr_fire = !i_rst && (state == IDLE) && !bus.i_send && bus.i_wr_en && !full;

  // NOTE: the message buffer has no reset; clearing count is enough to discard
  // its contents, and leaving it unreset lets it map onto plain storage.
  always_ff @(posedge i_clk) begin
    if (wr_fire) msg_mem[count] <= bus.i_wr_data;
  end

  // NOTE: all state updates use non-blocking assignments so every branch reads
  // the pre-edge values, which keeps the tx level aligned with the state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      count    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (bus.i_send) begin
            if (count != 3'd0) begin
              state    <= START;
              tx       <= 1'b0;
              busy     <= 1'b1;
              baud_cnt <= '0;
              bit_idx  <= '0;
              byte_idx <= '0;
            end else begin
              done <= 1'b1;
            end
          end else if (wr_fire) begin
            count <= count + 3'd1;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= msg_mem[byte_idx][0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= msg_mem[byte_idx][bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (byte_idx == count - 3'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              count <= '0;
              tx    <= 1'b1;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_tx    = tx;
  assign bus.o_busy  = busy;
  assign bus.o_done  = done;
  assign bus.o_count = count;
  assign bus.o_full  = full;

endmodule

// File: tb/tb_uart_tx_message_sender.sv
// Directed bench for uart_tx_message_sender with CLKS_PER_BIT=4, MSG_LEN=6.
// Outputs are sampled 1 ns after each rising edge; "cycle n" is the state after the n-th edge.
module tb_uart_tx_message_sender;

  localparam int CPB = 4;
  localparam int ML  = 6;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  uart_tx_message_sender_if bus ();

  uart_tx_message_sender #(.CLKS_PER_BIT(CPB), .MSG_LEN(ML)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       send;
    logic [2:0] exp_count;
    logic       exp_full;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr_en, input logic [7:0] data, input logic send);
    bus.i_wr_en   = wr_en;
    bus.i_wr_data = data;
    bus.i_send    = send;
  endtask

  task automatic write_byte(input logic [7:0] data);
    drive(1'b1, data, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
  endtask

  // Called at cycle 1 after the send edge. Expects n frames from msg (byte k at
  // msg[8k +: 8]); o_count must hold at n throughout. Clears inputs at the end.
  task automatic check_frames(input string name, input logic [55:0] msg, input int n);
    logic       ok_bit;
    logic       ok_busy;
    logic       ok_count;
    logic       level;
    logic [7:0] b;
    ok_busy  = 1'b1;
    ok_count = 1'b1;
    for (int k = 0; k < n; k++) begin
      b = msg[k*8 +: 8];
      for (int p = 0; p < 10; p++) begin
        level  = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
        ok_bit = 1'b1;
        for (int c = 0; c < CPB; c++) begin
          if (bus.o_tx !== level) ok_bit = 1'b0;
          if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) ok_busy = 1'b0;
          if (bus.o_count !== 3'(n)) ok_count = 1'b0;
          tick();
        end
        check($sformatf("%s_byte%0d_bit%0d", name, k, p), {31'd0, ok_bit}, 32'd1);
      end
    end
    check($sformatf("%s_busy_held", name), {31'd0, ok_busy}, 32'd1);
    check($sformatf("%s_count_held", name), {31'd0, ok_count}, 32'd1);
    check($sformatf("%s_done", name), {31'd0, bus.o_done}, 32'd1);
    check($sformatf("%s_busy_end", name), {31'd0, bus.o_busy}, 32'd0);
    check($sformatf("%s_count_end", name), {29'd0, bus.o_count}, 32'd0);
    check($sformatf("%s_tx_end", name), {31'd0, bus.o_tx}, 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    check($sformatf("%s_done_single", name), {31'd0, bus.o_done}, 32'd0);
  endtask

  vec_t       vecs[8];
  logic [55:0] msg;
  logic        ok;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check("rst_tx", {31'd0, bus.o_tx}, 32'd1);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    check("rst_count", {29'd0, bus.o_count}, 32'd0);
    check("rst_full", {31'd0, bus.o_full}, 32'd0);
    rst = 1'b0;
    tick();

    // Single byte 0x48: start bit at cycle 1, o_done at cycle 41.
    write_byte(8'h48);
    check("b48_count", {29'd0, bus.o_count}, 32'd1);
    check("b48_tx_idle", {31'd0, bus.o_tx}, 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    msg = '0;
    msg[7:0] = 8'h48;
    check_frames("b48", msg, 1);

    // "Hello": five back-to-back frames, 200 cycles.
    write_byte(8'h48);
    write_byte(8'h65);
    write_byte(8'h6C);
    write_byte(8'h6C);
    write_byte(8'h6F);
    check("hello_count", {29'd0, bus.o_count}, 32'd5);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    msg = {16'h0000, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48};
    check_frames("hello", msg, 5);

    // Fill past capacity: seventh write must be dropped.
    vecs[0] = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h05, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h06, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h07, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].send);
      tick();
      check($sformatf("vec%0d_count", i), {29'd0, bus.o_count}, {29'd0, vecs[i].exp_count});
      check($sformatf("vec%0d_full", i), {31'd0, bus.o_full}, {31'd0, vecs[i].exp_full});
      check($sformatf("vec%0d_busy", i), {31'd0, bus.o_busy}, {31'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d_done", i), {31'd0, bus.o_done}, {31'd0, vecs[i].exp_done});
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    msg = {8'h00, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    check_frames("full", msg, 6);

    // Empty send: o_done one cycle later, no frame.
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    check("empty_done", {31'd0, bus.o_done}, 32'd1);
    check("empty_busy", {31'd0, bus.o_busy}, 32'd0);
    check("empty_tx", {31'd0, bus.o_tx}, 32'd1);
    tick();
    check("empty_done_single", {31'd0, bus.o_done}, 32'd0);

    // Write+send together with one byte buffered; keep writing and sending while busy.
    write_byte(8'h5A);
    drive(1'b1, 8'hC3, 1'b1);
    tick();
    msg = '0;
    msg[7:0] = 8'h5A;
    check_frames("wrsend", msg, 1);

    // Reset during DATA bit 3 of 0xAA (cycles 17..20); reset also carries write+send.
    write_byte(8'hAA);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 1; i < 18; i++) tick();
    check("abort_pre_busy", {31'd0, bus.o_busy}, 32'd1);
    check("abort_pre_tx_bit3", {31'd0, bus.o_tx}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 8'h11, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check("abort_tx", {31'd0, bus.o_tx}, 32'd1);
    check("abort_busy", {31'd0, bus.o_busy}, 32'd0);
    check("abort_count", {29'd0, bus.o_count}, 32'd0);
    check("abort_done", {31'd0, bus.o_done}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1) ok = 1'b0;
    end
    check("abort_quiet", {31'd0, ok}, 32'd1);
    check("abort_buffer_empty", {29'd0, bus.o_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_message_sender.md
UART_TX_MESSAGE_SENDER -- requirements
Module: uart_tx_message_sender

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning i_clk cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter MSG_LEN, default 6, meaning message buffer depth in bytes (legal range 1..7).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_wr_en, input, 1 bit: append i_wr_data to the message buffer.
REQ-006 The block SHALL have port i_wr_data, input, 8 bits: byte to append.
REQ-007 The block SHALL have port i_send, input, 1 bit: start transmitting the buffered message.
REQ-008 The block SHALL have port o_tx, output, 1 bit: UART serial line, 8N1, LSB first, idle high.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high while a message is being transmitted.
REQ-010 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when a message completes.
REQ-011 The block SHALL have port o_count, output, 3 bits: number of bytes currently buffered.
REQ-012 The block SHALL have port o_full, output, 1 bit: high when o_count == MSG_LEN.

Function
REQ-013 In IDLE, the block SHALL write i_wr_data at index o_count and increment o_count on the next edge when i_wr_en=1, o_full=0, and i_send=0.
REQ-014 The block SHALL drop writes when o_full=1, when o_busy=1, or when i_send=1 in the same cycle; i_send takes priority.
REQ-015 The FSM SHALL have states IDLE, START, DATA, and STOP; the reset state is IDLE.
REQ-016 IDLE -> START SHALL occur on i_send=1 with o_count>0; o_tx goes low and o_busy goes high on the next edge.
REQ-017 i_send=1 with o_count=0 SHALL produce an o_done pulse on the next cycle, send no frame, and leave o_busy=0.
REQ-018 The START, each DATA bit, and STOP SHALL each hold o_tx for exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
REQ-019 The block SHALL transmit bytes in index order 0..o_count-1; the LSB of each byte is sent first; the STOP level is 1.
REQ-020 After the STOP of a byte that is not the last, START of the next byte SHALL follow immediately, with no idle gap.
REQ-021 After the STOP of the last byte, the block SHALL return to IDLE: o_busy=0 and o_done=1 for one cycle, o_count=0, and o_tx=1.
REQ-022 While busy, i_send SHALL be ignored, and buffer contents and o_count SHALL stay unchanged until completion.
REQ-023 The bit counter (0..7) and baud counter (0..CLKS_PER_BIT-1) SHALL wrap without overflow, and the baud counter SHALL be cleared on each state entry.
REQ-024 o_tx, o_busy, and o_done SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-025 When i_rst=1, on the next edge the block SHALL set state=IDLE, o_tx=1, o_busy=0, o_done=0, o_count=0, and o_full=0, and clear all counters.
REQ-026 When i_rst is asserted mid-frame, the block SHALL abort the frame and drive o_tx high on the next edge, with no o_done pulse.
REQ-027 When i_rst is asserted, buffer contents SHALL be discarded and i_wr_en/i_send ignored in that cycle.

Verification (CLKS_PER_BIT=4, MSG_LEN=6)
REQ-028 Write 0x48, then assert i_send -> o_tx is high then low at +1 cycle, bits 0,0,0,1,0,0,1,0 at 4 cycles each, stop high, and o_done pulses at cycle 41 after i_send.
REQ-029 Write "Hello" (48 65 6C 6C 6F), then send -> five back-to-back frames totalling 200 cycles, o_busy high throughout, o_count=0 after o_done.
REQ-030 Write 7 bytes 0x01..0x07 -> o_full=1 after the sixth write, o_count=6, the seventh write is dropped, and sending produces 0x01..0x06 only.
REQ-031 Assert i_send with an empty buffer -> o_done pulses one cycle later, o_tx stays high, o_busy stays 0.
REQ-032 Send 0xAA and assert i_rst during DATA bit 3 -> o_tx=1 on the next edge, o_busy=0, o_count=0, and no o_done pulse.
REQ-033 With i_wr_en and i_send asserted together with o_count=1 -> one frame is sent and the new byte is not stored; writes during busy leave o_count unchanged.
